// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants, state encoding and width helper for the nibble-serial add/sub sequencer.
package nibble_serial_addsub_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; a pass counter for n passes needs clog2(n) bits (0 for n==1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? (n - 1) : 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_addc.sv
// 4-bit ripple-carry slice; exposes the carry into bit 3 for signed overflow.
module nibble_addc
  import nibble_serial_addsub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                c4
);

  logic [3:0] lo;
  logic [1:0] hi;

  // Low three bits first so the carry into the MSB is directly observable.
  always_comb begin
    lo = 4'(a[2:0]) + 4'(b[2:0]) + 4'(cin);
    hi = 2'(a[3]) + 2'(b[3]) + 2'(lo[3]);
    s  = {hi[0], lo[2:0]};
    c3 = lo[3];
    c4 = hi[1];
  end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Sequencer running a W-bit add/sub through one shared 4-bit slice, LSB nibble first.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  result,
  output logic                         cout,
  output logic                         ovf_unsigned,
  output logic                         ovf_signed
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned CNT_W = (clog2(NIBBLES) > 0) ? clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic               op_sub_q, op_sub_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic [W-1:0]       res_sh_q, res_sh_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovfu_q, ovfu_d;
  logic               ovfs_q, ovfs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIBBLE_W-1:0] sum;
  logic                c3;
  logic                c4;

  nibble_addc u_addc (
    .a   (a_sh_q[NIBBLE_W-1:0]),
    .b   (b_sh_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .s   (sum),
    .c3  (c3),
    .c4  (c4)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      op_sub_q <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovfu_q   <= 1'b0;
      ovfs_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      op_sub_q <= op_sub_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovfu_q   <= ovfu_d;
      ovfs_q   <= ovfs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, operand load, per-nibble pass and final flag capture.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    op_sub_d = op_sub_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovfu_d   = ovfu_q;
    ovfs_d   = ovfs_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Each result nibble enters at the top so the LSB nibble ends at bit 0.
        res_sh_d = W'({sum, res_sh_q} >> NIBBLE_W);
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        carry_d  = c4;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d  = ST_DONE;
          result_d = res_sh_d;
          cout_d   = c4;
          ovfu_d   = op_sub_q ? ~c4 : c4;
          ovfs_d   = c3 ^ c4;
        end
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Subtraction is a + ~b + 1, so the inverted operand and carry-in are loaded here.
    if (start && (state_q != ST_RUN)) begin
      a_sh_d   = a;
      b_sh_d   = sub ? ~b : b;
      carry_d  = sub;
      op_sub_d = sub;
      count_d  = '0;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign cout         = cout_q;
  assign ovf_unsigned = ovfu_q;
  assign ovf_signed   = ovfs_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for the nibble-serial add/sub sequencer at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_addsub_ctrl;

  logic        clk;
  logic        rst4, rst1;
  logic        start, sub_r, sel;
  logic [15:0] a_r, b_r;

  logic        busy4, done4, cout4, ovu4, ovs4;
  logic [15:0] res4;
  logic        busy1, done1, cout1, ovu1, ovs1;
  logic [3:0]  res1;

  logic        busy_m, done_m, cout_m, ovu_m, ovs_m;
  logic [15:0] result_m;

  int total = 0;
  int bad   = 0;
  logic [15:0] last4, last1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start & ~sel), .sub(sub_r),
    .a(a_r), .b(b_r), .busy(busy4), .done(done4), .result(res4),
    .cout(cout4), .ovf_unsigned(ovu4), .ovf_signed(ovs4)
  );

  nibble_serial_addsub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start & sel), .sub(sub_r),
    .a(a_r[3:0]), .b(b_r[3:0]), .busy(busy1), .done(done1), .result(res1),
    .cout(cout1), .ovf_unsigned(ovu1), .ovf_signed(ovs1)
  );

  assign busy_m   = sel ? busy1 : busy4;
  assign done_m   = sel ? done1 : done4;
  assign cout_m   = sel ? cout1 : cout4;
  assign ovu_m    = sel ? ovu1  : ovu4;
  assign ovs_m    = sel ? ovs1  : ovs4;
  assign result_m = sel ? {12'h000, res1} : res4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: accept, optional start poke during RUN, bounded wait for done, checks.
  task automatic do_op(input string tag, input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] er, input logic ec, input logic eu, input logic es,
                       input int elat, input bit b2b, input int poke);
    int n;
    int busy_n;
    n = 0;
    busy_n = 0;
    if (!b2b) @(negedge clk);
    start = 1'b1; sub_r = s; a_r = av; b_r = bv;
    @(negedge clk);
    start = 1'b0; a_r = '0; b_r = '0;
    chk({tag, "_acc_busy"}, busy_m, 1);
    chk({tag, "_acc_done"}, done_m, 0);
    while (!done_m && n < 20) begin
      if (busy_m) busy_n++;
      if (n == 1) chk({tag, "_hold"}, result_m, sel ? last1 : last4);
      if (n == poke) begin
        start = 1'b1; sub_r = 1'b0; a_r = 16'hFFFF; b_r = 16'hFFFF;
      end else begin
        start = 1'b0; a_r = '0; b_r = '0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_busycyc"}, busy_n, elat);
    chk({tag, "_res"}, result_m, er);
    chk({tag, "_cout"}, cout_m, ec);
    chk({tag, "_ovu"}, ovu_m, eu);
    chk({tag, "_ovs"}, ovs_m, es);
    if (sel) last1 = er; else last4 = er;
  endtask

  initial begin
    bit seen;
    rst4 = 1'b1; rst1 = 1'b1; start = 1'b0; sub_r = 1'b0; sel = 1'b0;
    a_r = '0; b_r = '0; last4 = '0; last1 = '0;
    #12;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_res", res4, 16'h0000);
    chk("rst_flags", {cout4, ovu4, ovs4}, 3'b000);
    @(negedge clk);
    rst4 = 1'b0; rst1 = 1'b0;

    do_op("add_basic", 0, 16'h1234, 16'h0FED, 16'h2221, 0, 0, 0, 4, 0, -1);
    @(negedge clk);
    chk("done_pulse_drop", done_m, 0);
    chk("idle_busy", busy_m, 0);
    do_op("add_sovf", 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 4, 0, -1);
    do_op("add_wrap", 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 4, 0, -1);
    do_op("sub_borrow", 1, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 0, 4, 0, -1);
    do_op("sub_sovf", 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 1, 4, 0, -1);
    do_op("start_in_run", 0, 16'h1234, 16'h0FED, 16'h2221, 0, 0, 0, 4, 0, 1);
    do_op("back2back", 0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 4, 1, -1);

    // Asynchronous reset in the second RUN cycle.
    @(negedge clk);
    start = 1'b1; sub_r = 1'b0; a_r = 16'h1234; b_r = 16'h0FED;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    chk("arst_busy", busy_m, 0);
    chk("arst_done", done_m, 0);
    chk("arst_res", result_m, 16'h0000);
    chk("arst_flags", {cout_m, ovu_m, ovs_m}, 3'b000);
    @(negedge clk);
    rst4 = 1'b0;
    last4 = '0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_m) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    do_op("after_rst", 0, 16'hA5A5, 16'h1111, 16'hB6B6, 0, 0, 0, 4, 0, -1);

    sel = 1'b1;
    do_op("n1_add", 0, 16'h0007, 16'h0001, 16'h0008, 0, 0, 1, 1, 0, -1);
    do_op("n1_sub", 1, 16'h0000, 16'h0001, 16'h000F, 0, 1, 0, 1, 0, -1);
    @(negedge clk);
    chk("n1_done_drop", done_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
